// File: rtl/wptr_full_prog.sv
// Write-domain Gray pointer, full/almost-full flags, registered fill level and
// optional sticky overflow flag (build with `define WPTR_FULL_OVF_EN to enable it).
module wptr_full_prog #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                wclr_ovf,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                awfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SYNC_STAGES-1:0][ADDRSIZE:0] rsync_q;
  logic [ADDRSIZE:0] rq_gray_s;
  logic [ADDRSIZE:0] rq_bin_s;
  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic              wfull_q, wfull_d;
  logic              awfull_q, awfull_d;

  // Read-pointer synchronizer; index 0 is the stage nearest the rptr input.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rsync_q <= '0;
    end else begin
      rsync_q <= {rsync_q[SYNC_STAGES-2:0], rptr};
    end
  end

  assign rq_gray_s = rsync_q[SYNC_STAGES-1];

  // Next pointer, level and flag values; the level uses the post-write pointer
  // so a write and a synchronized read in the same cycle both count.
  always_comb begin
    wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, (winc & ~wfull_q)};
    wptr_d   = (wbin_d >> 1) ^ wbin_d;
    rq_bin_s = gray2bin(rq_gray_s);
    wlevel_d = wbin_d - rq_bin_s;
    wfull_d  = (wptr_d == {~rq_gray_s[ADDRSIZE:ADDRSIZE-1], rq_gray_s[ADDRSIZE-2:0]});
    awfull_d = (wlevel_d >= afull_thresh);
  end

  // Pointer, level and flag registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
    end
  end

  assign waddr  = wbin_q[ADDRSIZE-1:0];
  assign wptr   = wptr_q;
  assign wlevel = wlevel_q;
  assign wfull  = wfull_q;
  assign awfull = awfull_q;

`ifdef WPTR_FULL_OVF_EN
  logic wovf_q, wovf_d;

  // Sticky overflow: a write against a full FIFO sets it and beats a clear.
  always_comb begin
    if (winc && wfull_q) begin
      wovf_d = 1'b1;
    end else if (wclr_ovf) begin
      wovf_d = 1'b0;
    end else begin
      wovf_d = wovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf_q <= 1'b0;
    end else begin
      wovf_q <= wovf_d;
    end
  end

  assign wovf = wovf_q;
`else
  logic unused_wclr_ovf_s;
  assign unused_wclr_ovf_s = wclr_ovf;
  assign wovf = 1'b0;
`endif

endmodule
